// File: rtl/backing_memory_responder_pkg.sv
// Shared constants for the backing memory responder and its latency counter.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
// Contents: word width, FSM state encodings, operation codes, counter width helper.
package backing_memory_responder_pkg;

  localparam int WORD_W = 32;

  // FSM state encodings, kept as plain constants so legacy code can share them.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Captured operation code.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Counter width able to hold the larger of the two latencies minus one,
  // with one bit of headroom.
  function automatic int cnt_width(input int read_lat, input int write_lat);
    int m;
    m = (read_lat > write_lat) ? read_lat : write_lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/backing_memory_responder_counter.sv
// Loadable down-counter that times the BUSY phase; also usable as a miss-stall counter.
// Latency: load and decrement take effect on the next rising edge; flags are combinational from count.
// Backpressure: none; decrement saturates at zero.
// Ports: clk, rst (async, active-high), load/load_value (parallel load, wins over dec),
//        dec (decrement enable), zero (count is 0), last (count is 1, next decrement reaches 0).
module latency_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/backing_memory_responder.sv
// Word-addressed main-memory model answering cache fills and write-throughs with fixed latency.
// Latency: request sampled at edge 0, ready pulses during cycle READ_LATENCY / WRITE_LATENCY.
// Backpressure: none to the initiator; requests arriving while not IDLE are ignored, bad ones pulse error.
// Ports: clk, reset (async, active-high), memRead/memWrite (requests), address (byte address),
//        value (write data), out (read data, held until next read completes),
//        ready (one-cycle completion), busy (between sample and ready), error (one-cycle reject).
module backing_memory_responder
  import backing_memory_responder_pkg::*;
#(
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int INIT_STEP     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] value,
  output logic [WORD_W-1:0] out,
  output logic              ready,
  output logic              busy,
  output logic              error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY);

  logic [1:0]            state;
  logic [1:0]            state_next;

  // Captured request; inputs are not looked at again until the next IDLE.
  logic                  cap_op;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [WORD_W-1:0]     cap_data;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  aligned;
  logic                  in_range;
  logic                  one_req;
  logic                  accept;
  logic                  reject;
  logic [CNT_W-1:0]      lat_m1;

  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;
  logic                  cnt_last;

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_op;
  logic [WORD_W-1:0]     rd_word;
  logic                  commit;

  // Request decode and checks, only meaningful while IDLE.
  assign req_idx  = address[DEPTH_LOG2+1:2];
  assign aligned  = (address[1:0] == 2'b00);
  assign in_range = (address[WORD_W-1:DEPTH_LOG2+2] == '0);
  assign one_req  = memRead ^ memWrite;
  assign accept   = (state == IDLE) && one_req && aligned && in_range;
  assign reject   = (state == IDLE) && (memRead || memWrite) && !(one_req && aligned && in_range);
  assign lat_m1   = memWrite ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

  latency_counter #(
    .WIDTH(CNT_W)
  ) u_latency_counter (
    .clk       (clk),
    .rst       (reset),
    .load      (cnt_load),
    .load_value(lat_m1),
    .dec       (cnt_dec),
    .zero      (cnt_zero),
    .last      (cnt_last)
  );

  // The counter holds the BUSY cycles still to run, including the current
  // one, so BUSY ends on the cycle where it reads 1. A zero load (latency 1)
  // skips BUSY entirely.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_load   = 1'b1;
          state_next = (lat_m1 == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cap_op   <= OP_READ;
      cap_idx  <= '0;
      cap_data <= '0;
      error    <= 1'b0;
    end else begin
      state <= state_next;
      error <= reject;
      if (accept) begin
        cap_op   <= memWrite ? OP_WRITE : OP_READ;
        cap_idx  <= req_idx;
        cap_data <= value;
      end
    end
  end

  assign busy  = (state == BUSY);
  assign ready = (state == RESP);

  // Storage. The written map is the configuration-time image: words never
  // written since configuration read back as index*INIT_STEP. Neither the
  // map nor the array is touched by reset.
  logic [WORD_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written = '0;

  // A write commits only on the edge that ends RESP. An asserted reset has
  // already forced IDLE asynchronously, so an aborted write never lands.
  assign commit = (state == RESP) && (cap_op == OP_WRITE);

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cap_idx]     <= cap_data;
      written[cap_idx] <= 1'b1;
    end
  end

  // Read data is registered on the edge entering RESP so it is valid with
  // ready. With latency 1 that edge is the sampling edge, so the live
  // request is used instead of the not-yet-captured copy.
  assign rd_idx  = (state == IDLE) ? req_idx : cap_idx;
  assign rd_op   = (state == IDLE) ? (memWrite ? OP_WRITE : OP_READ) : cap_op;
  assign rd_word = written[rd_idx] ? mem[rd_idx]
                                   : WORD_W'(rd_idx) * WORD_W'(INIT_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if ((state_next == RESP) && (state != RESP) && (rd_op == OP_READ)) begin
      out <= rd_word;
    end
  end

endmodule

// File: tb/tb_backing_memory_responder.sv
// Directed bench for backing_memory_responder with default parameters.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: requests are dropped one cycle after being driven unless a test holds them.
module tb_backing_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] value = '0;
  logic [31:0] out;
  logic        ready;
  logic        busy;
  logic        error;

  int total = 0;
  int bad = 0;

  // Results of the last run_req call.
  int          r_cyc;
  int          r_cnt;
  int          b_cnt;
  int          e_cnt;
  logic [31:0] r_dat;

  backing_memory_responder dut (
    .clk     (clk),
    .reset   (reset),
    .memRead (memRead),
    .memWrite(memWrite),
    .address (address),
    .value   (value),
    .out     (out),
    .ready   (ready),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Drives one request at a falling edge and watches a fixed window of
  // cycles; cycle c is the one after the c-th rising edge following the drive.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] v, input int max_cyc);
    memRead  = rd;
    memWrite = wr;
    address  = a;
    value    = v;
    r_cyc = -1;
    r_cnt = 0;
    b_cnt = 0;
    e_cnt = 0;
    r_dat = 'x;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        memRead  = 1'b0;
        memWrite = 1'b0;
      end
      if (busy) b_cnt++;
      if (error) e_cnt++;
      if (ready) begin
        r_cnt++;
        if (r_cyc < 0) begin
          r_cyc = c;
          r_dat = out;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    memRead = 1'b1;
    address = 32'h0000_0014;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) memRead = 1'b0;
      total++;
      if (busy !== (c <= 3)) begin bad++; $display("FAIL rd_lat_busy cyc=%0d got=%b exp=%b", c, busy, (c <= 3)); end
      total++;
      if (ready !== (c == 4)) begin bad++; $display("FAIL rd_lat_ready cyc=%0d got=%b exp=%b", c, ready, (c == 4)); end
      if (c >= 4) begin
        total++;
        if (out !== 32'd25) begin bad++; $display("FAIL rd_lat_out cyc=%0d got=%h exp=%h", c, out, 32'd25); end
      end
    end
  endtask

  task automatic test_write_read();
    run_req(1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 6);
    total++; if (r_cyc != 2) begin bad++; $display("FAIL wr_ready_cycle got=%0d exp=2", r_cyc); end
    total++; if (r_cnt != 1) begin bad++; $display("FAIL wr_ready_count got=%0d exp=1", r_cnt); end
    total++; if (b_cnt != 1) begin bad++; $display("FAIL wr_busy_cycles got=%0d exp=1", b_cnt); end
    run_req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 8);
    total++; if (r_cyc != 4) begin bad++; $display("FAIL raw_ready_cycle got=%0d exp=4", r_cyc); end
    total++; if (r_dat !== 32'hDEAD_BEEF) begin bad++; $display("FAIL raw_data got=%h exp=deadbeef", r_dat); end
  endtask

  task automatic test_reject();
    logic        rds [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        wrs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ads [4] = '{32'h0000_1000, 32'h0000_0006, 32'h0000_0010, 32'h0000_0006};
    for (int i = 0; i < 4; i++) begin
      run_req(rds[i], wrs[i], ads[i], 32'h5555_AAAA, 7);
      total++; if (e_cnt != 1) begin bad++; $display("FAIL rej_error case=%0d got=%0d exp=1", i, e_cnt); end
      total++; if (r_cnt != 0) begin bad++; $display("FAIL rej_ready case=%0d got=%0d exp=0", i, r_cnt); end
      total++; if (b_cnt != 0) begin bad++; $display("FAIL rej_busy case=%0d got=%0d exp=0", i, b_cnt); end
    end
    // Neither the dual request nor the misaligned write may have changed memory.
    run_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 6);
    total++; if (r_dat !== 32'd20) begin bad++; $display("FAIL rej_word4 got=%h exp=%h", r_dat, 32'd20); end
    run_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 6);
    total++; if (r_dat !== 32'd5) begin bad++; $display("FAIL rej_word1 got=%h exp=%h", r_dat, 32'd5); end
  endtask

  task automatic test_range_edge();
    run_req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 6);
    total++; if (e_cnt != 0) begin bad++; $display("FAIL top_word_error got=%0d exp=0", e_cnt); end
    total++; if (r_dat !== 32'd5115) begin bad++; $display("FAIL top_word_data got=%h exp=%h", r_dat, 32'd5115); end
  endtask

  task automatic test_capture();
    int rc;
    int rcnt;
    rc = -1;
    rcnt = 0;
    memWrite = 1'b1;
    address  = 32'h0000_0004;
    value    = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        memWrite = 1'b0;
        address  = 32'h0000_000C;
        value    = 32'hFFFF_FFFF;
      end
      if (ready) begin
        rcnt++;
        if (rc < 0) rc = c;
      end
    end
    total++; if (rc != 2 || rcnt != 1) begin bad++; $display("FAIL cap_ready cyc=%0d count=%0d exp cyc=2 count=1", rc, rcnt); end
    run_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 6);
    total++; if (r_dat !== 32'h1234_5678) begin bad++; $display("FAIL cap_word1 got=%h exp=12345678", r_dat); end
    run_req(1'b1, 1'b0, 32'h0000_000C, 32'h0, 6);
    total++; if (r_dat !== 32'd15) begin bad++; $display("FAIL cap_word3 got=%h exp=%h", r_dat, 32'd15); end
  endtask

  task automatic test_reset_abort();
    memWrite = 1'b1;
    address  = 32'h0000_000C;
    value    = 32'hAAAA_5555;
    @(negedge clk);
    memWrite = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", ready); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL abort_out got=%h exp=0", out); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL abort_error got=%b exp=0", error); end
    @(negedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready_held got=%b exp=0", ready); end
    reset = 1'b0;
    run_req(1'b1, 1'b0, 32'h0000_000C, 32'h0, 6);
    total++; if (r_cnt != 1) begin bad++; $display("FAIL abort_read_ready got=%0d exp=1", r_cnt); end
    total++; if (r_dat !== 32'd15) begin bad++; $display("FAIL abort_read_data got=%h exp=%h", r_dat, 32'd15); end
  endtask

  task automatic test_hold_read();
    memRead = 1'b1;
    address = 32'h0000_0014;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      total++;
      if (ready !== ((c % 5) == 4)) begin
        bad++;
        $display("FAIL hold_ready cyc=%0d got=%b exp=%b", c, ready, ((c % 5) == 4));
      end
    end
    memRead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    // Minimum turnaround: the next request is driven in the first IDLE cycle.
    run_req(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 3);
    total++; if (r_cyc != 2) begin bad++; $display("FAIL b2b_write_ready got=%0d exp=2", r_cyc); end
    run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 5);
    total++; if (r_cyc != 4) begin bad++; $display("FAIL b2b_read_ready got=%0d exp=4", r_cyc); end
    total++; if (r_dat !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_read_data got=%h exp=0badf00d", r_dat); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_reject();
    test_range_edge();
    test_capture();
    test_reset_abort();
    test_hold_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
